// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory responder.
package imem_pkg;

    localparam logic [31:0] HALT_INSTR = 32'h0000007F;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;
    localparam int          LANE_W     = 8;
    localparam int          LANES      = 4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

endpackage

// File: rtl/imem_byte_assembler.sv
// Collects little-endian program bytes into 32-bit words; word_done marks the
// cycle the fourth byte arrives, with word_data already including that byte.
module imem_byte_assembler
    import imem_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      byte_valid,
    input  logic [LANE_W-1:0]         byte_in,
    output logic                      word_done,
    output logic [LANES*LANE_W-1:0]   word_data,
    output logic [1:0]                byte_cnt
);

    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [LANES*LANE_W-1:0] asm_q, asm_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_q <= '0;
            asm_q      <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
        end
    end

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        word_data  = asm_q;
        word_data[{byte_cnt_q, 3'b000} +: LANE_W] = byte_in;
        word_done  = byte_valid && (byte_cnt_q == 2'd3);
        // A completing byte is still reported even when clear fires with it.
        if (clear) begin
            byte_cnt_d = '0;
            asm_d      = '0;
        end else if (byte_valid) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            asm_d      = word_done ? '0 : word_data;
        end
    end

    assign byte_cnt = byte_cnt_q;

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory with byte-wide program load and 1-cycle fetch port.
// Optional IMEM_LOAD_CHECKSUM_EN adds a modulo-256 sum of accepted load bytes.
module instr_mem_responder
    import imem_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    output logic              load_ready,
    input  logic              fetch_req,
    input  logic [WIDTH-1:0]  fetch_addr,
    output logic              fetch_valid,
    output logic [WIDTH-1:0]  fetch_instr,
    output logic              fetch_err,
    output logic [AW:0]       loaded_words,
    output state_t            state_dbg
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    output logic [7:0]        load_checksum
`endif
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    state_t             state_q, state_d;
    logic [AW:0]        loaded_words_q, loaded_words_d;
    logic               fetch_valid_q, fetch_valid_d;
    logic [WIDTH-1:0]   fetch_instr_q, fetch_instr_d;
    logic               fetch_err_q, fetch_err_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               load_entry, load_exit, asm_clear, accept;
    logic               word_done;
    logic [31:0]        word_data;
    logic [1:0]         byte_cnt;
    logic [AW-1:0]      fetch_idx;
    logic               fetch_bad;

    imem_byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_valid (accept),
        .byte_in    (load_byte),
        .word_done  (word_done),
        .word_data  (word_data),
        .byte_cnt   (byte_cnt)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_RUN;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (load_en)  state_d = ST_LOAD;
            ST_LOAD: if (!load_en) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        load_entry = (state_q == ST_RUN) && load_en;
        load_exit  = (state_q == ST_LOAD) && !load_en;
        asm_clear  = load_entry || load_exit;
        load_ready = (state_q == ST_LOAD) && (loaded_words_q < DEPTH_W);
        accept     = load_valid && load_ready;
    end

    // Fetch decision uses the pre-edge count, so a fetch alongside load entry
    // still sees the old program.
    always_comb begin
        fetch_idx      = fetch_addr[AW+1:2];
        fetch_bad      = (fetch_addr[1:0] != 2'b00) || (|fetch_addr[WIDTH-1:AW+2]) ||
                         ({1'b0, fetch_idx} >= loaded_words_q);
        fetch_valid_d  = fetch_req && (state_q == ST_RUN);
        fetch_instr_d  = fetch_instr_q;
        fetch_err_d    = 1'b0;
        if (fetch_valid_d) begin
            fetch_err_d   = fetch_bad;
            fetch_instr_d = fetch_bad ? WIDTH'(HALT_INSTR) : mem_q[fetch_idx];
        end

        loaded_words_d = loaded_words_q;
        if (load_entry)
            loaded_words_d = '0;
        else if (accept && word_done)
            loaded_words_d = loaded_words_q + (AW + 1)'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            loaded_words_q <= '0;
            fetch_valid_q  <= 1'b0;
            fetch_instr_q  <= '0;
            fetch_err_q    <= 1'b0;
        end else begin
            loaded_words_q <= loaded_words_d;
            fetch_valid_q  <= fetch_valid_d;
            fetch_instr_q  <= fetch_instr_d;
            fetch_err_q    <= fetch_err_d;
        end
    end

    // Storage is not reset; entries above loaded_words are never returned.
    always_ff @(posedge clk) begin
        if (accept && word_done)
            mem_q[loaded_words_q[AW-1:0]] <= WIDTH'(word_data);
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (load_entry)  checksum_d = '0;
        else if (accept) checksum_d = checksum_q + load_byte;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) checksum_q <= '0;
        else      checksum_q <= checksum_d;
    end

    assign load_checksum = checksum_q;
`endif

    assign fetch_valid  = fetch_valid_q;
    assign fetch_instr  = fetch_instr_q;
    assign fetch_err    = fetch_err_q;
    assign loaded_words = loaded_words_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized scoreboard bench for instr_mem_responder against a word-list model.
// Handshake: a load byte transfers when load_valid && load_ready at a rising edge;
// fetch_req at an edge produces exactly one fetch_valid pulse after that edge.
module tb_instr_mem_responder;
    import imem_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              load_en = 0, load_valid = 0, fetch_req = 0;
    logic [7:0]        load_byte = 0;
    logic [WIDTH-1:0]  fetch_addr = 0;
    logic              load_ready, fetch_valid, fetch_err;
    logic [WIDTH-1:0]  fetch_instr;
    logic [AW:0]       loaded_words;
    state_t            state_dbg;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]        load_checksum;
`endif

    instr_mem_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_en      (load_en),
        .load_valid   (load_valid),
        .load_byte    (load_byte),
        .load_ready   (load_ready),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_valid  (fetch_valid),
        .fetch_instr  (fetch_instr),
        .fetch_err    (fetch_err),
        .loaded_words (loaded_words),
        .state_dbg    (state_dbg)
`ifdef IMEM_LOAD_CHECKSUM_EN
        ,
        .load_checksum(load_checksum)
`endif
    );

    // Reference model: list of committed words plus pending bytes
    logic [31:0] model_mem [DEPTH];
    int          model_count = 0;
    logic [7:0]  model_bytes [$];
    logic [7:0]  model_sum = 0;
    logic [31:0] last_instr = 0;

    logic [WIDTH:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Monitor: every response pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (rst && fetch_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_fetch_valid", 64'(fetch_valid), 64'd0);
            end else begin
                logic [WIDTH:0] e;
                e = exp_q.pop_front();
                check("fetch_resp", 64'({fetch_err, fetch_instr}), 64'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH:0] model_fetch(input logic [WIDTH-1:0] a);
        if (a[1:0] != 2'b00 || (a >> 2) >= model_count) return {1'b1, HALT_INSTR};
        return {1'b0, model_mem[a >> 2]};
    endfunction

    // Drive a fetch; when in_run is 0 the DUT must not answer.
    task automatic do_fetch(input logic [WIDTH-1:0] a, input bit in_run);
        logic [WIDTH:0] e;
        if (in_run) begin
            e = model_fetch(a);
            exp_q.push_back(e);
            last_instr = e[WIDTH-1:0];
        end
        fetch_req  = 1'b1;
        fetch_addr = a;
        tick();
        fetch_req  = 1'b0;
    endtask

    task automatic begin_load();
        load_en = 1'b1;
        tick();
        model_count = 0;
        model_bytes.delete();
        model_sum = 0;
    endtask

    task automatic end_load();
        load_en = 1'b0;
        load_valid = 1'b0;
        tick();
        model_bytes.delete();
    endtask

    task automatic model_accept(input logic [7:0] b);
        if (model_count < DEPTH) begin
            model_sum = model_sum + b;
            model_bytes.push_back(b);
            if (model_bytes.size() == 4) begin
                model_mem[model_count] = {model_bytes[3], model_bytes[2], model_bytes[1], model_bytes[0]};
                model_count++;
                model_bytes.delete();
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        model_accept(b);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic idle();
        tick();
        check("hold_valid_low", 64'(fetch_valid), 64'd0);
        check("hold_instr", 64'(fetch_instr), 64'(last_instr));
        check("hold_err_clear", 64'(fetch_err), 64'd0);
    endtask

    logic [7:0] prog2 [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    initial begin
        // Reset state
        #2;
        check("rst_fetch_valid", 64'(fetch_valid), 64'd0);
        check("rst_loaded_words", 64'(loaded_words), 64'd0);
        check("rst_load_ready", 64'(load_ready), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(ST_RUN));
        tick();
        rst = 1'b1;
        tick();

        // Fetch on empty memory
        do_fetch(32'h0, 1);
        idle();

        // Two-word program
        begin_load();
        check("load_state", 64'(state_dbg), 64'(ST_LOAD));
        check("load_ready_up", 64'(load_ready), 64'd1);
        foreach (prog2[i]) send_byte(prog2[i]);
        end_load();
        check("two_words", 64'(loaded_words), 64'd2);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("checksum_b6", 64'(load_checksum), 64'hB6);
`endif
        do_fetch(32'h0, 1);
        do_fetch(32'h4, 1);
        do_fetch(32'h8, 1);
        do_fetch(32'h2, 1);
        do_fetch(32'h8000_0000, 1);
        idle();
        do_fetch(32'h0, 1);
        do_fetch(32'h4, 1);
        idle();

        // Fetch in the same cycle load_en rises sees the old program
        load_en = 1'b1;
        exp_q.push_back(model_fetch(32'h4));
        last_instr = model_fetch(32'h4);
        fetch_req = 1'b1; fetch_addr = 32'h4;
        tick();
        fetch_req = 1'b0;
        model_count = 0; model_bytes.delete(); model_sum = 0;

        // Fill to capacity
        for (int i = 0; i < 4 * DEPTH; i++) begin
            send_byte(8'($urandom_range(0, 255)));
            if (i == 4 * DEPTH - 2) check("ready_before_full", 64'(load_ready), 64'd1);
        end
        check("ready_after_full", 64'(load_ready), 64'd0);
        send_byte(8'hEE);
        check("full_count", 64'(loaded_words), 64'(DEPTH));
        end_load();
        do_fetch(32'h3C, 1);
        do_fetch(32'h40, 1);
        idle();

        // Partial word discarded, lane restart after re-entry
        begin_load();
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1));
        end_load();
        check("partial_count", 64'(loaded_words), 64'd1);
        begin_load();
        check("reentry_count", 64'(loaded_words), 64'd0);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
        // Fourth byte coincides with load_en falling
        load_en = 1'b0; load_valid = 1'b1; load_byte = 8'hD4;
        model_accept(8'hD4);
        tick();
        load_valid = 1'b0;
        check("commit_on_exit", 64'(loaded_words), 64'd1);
        do_fetch(32'h0, 1);
        idle();

        // Randomized load/fetch rounds
        for (int r = 0; r < 8; r++) begin
            int nb;
            nb = $urandom_range(1, 70);
            begin_load();
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                send_byte(8'($urandom_range(0, 255)));
            end
            end_load();
            check("rand_count", 64'(loaded_words), 64'(model_count));
            for (int f = 0; f < 20; f++) begin
                logic [WIDTH-1:0] a;
                case ($urandom_range(0, 3))
                    0, 1: a = 32'($urandom_range(0, DEPTH + 1) * 4);
                    2:    a = 32'($urandom_range(0, 4 * DEPTH + 7));
                    default: a = $urandom;
                endcase
                do_fetch(a, 1);
                if ($urandom_range(0, 4) == 0) idle();
            end
            idle();
        end

        // Fetch during LOAD is ignored
        begin_load();
        do_fetch(32'h0, 0);
        check("load_fetch_novalid", 64'(fetch_valid), 64'd0);
        send_byte(8'h55);
        send_byte(8'h66);

        // Async reset mid-word
        #3 rst = 1'b0;
        #1;
        check("arst_loaded_words", 64'(loaded_words), 64'd0);
        check("arst_load_ready", 64'(load_ready), 64'd0);
        check("arst_instr", 64'(fetch_instr), 64'd0);
        check("arst_state", 64'(state_dbg), 64'(ST_RUN));
        load_en = 1'b0;
        model_count = 0; model_bytes.delete(); model_sum = 0; last_instr = 0;
        tick();
        rst = 1'b1;
        tick();
        do_fetch(32'h0, 1);
        idle();
        tick();

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
